// File: rtl/bios_stream_loader_pkg.sv
// Shared types and constants for the BIOS byte-stream loader.
// Frame: SYNC, LEN(4B LE), BASE(4B LE), N*4 data bytes, CSUM.
package bios_stream_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_BASE,
    ST_DATA,
    ST_CSUM
  } state_e;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int unsigned FIELD_BYTES = 4;

endpackage

// File: rtl/loader_word_assembler.sv
// Little-endian byte-to-word assembler shared by LEN, BASE and DATA fields.
// word_valid_o fires combinationally with the 4th byte of each word.
module loader_word_assembler
  import bios_stream_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  logic [1:0]  idx_q, idx_d;
  logic [23:0] acc_q, acc_d;

  assign word_valid_o = byte_valid_i
                      & (idx_q == 2'(FIELD_BYTES - 1));
  assign word_o = {byte_i, acc_q};

  always_comb begin
    idx_d = idx_q;
    acc_d = acc_q;
    if (clr_i) begin
      idx_d = '0;
      acc_d = '0;
    end else if (byte_valid_i) begin
      idx_d = idx_q + 2'd1;
      unique case (idx_q)
        2'd0:    acc_d[7:0]   = byte_i;
        2'd1:    acc_d[15:8]  = byte_i;
        2'd2:    acc_d[23:16] = byte_i;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q <= '0;
      acc_q <= '0;
    end else begin
      idx_q <= idx_d;
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/bios_stream_loader.sv
// Frame-parsing program loader: writes words to BIOS memory
// while holding the CPU in reset.
module bios_stream_loader
  import bios_stream_loader_pkg::*;
#(
  parameter int unsigned MEM_ADDR_WIDTH = 12,
  parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 50_000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [7:0]                rx_data,
  input  logic                      rx_valid,
  output logic                      rx_ready,
  output logic                      mem_we,
  output logic [3:0]                mem_wbe,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]               mem_din,
  output logic                      cpu_rst_hold,
  output logic                      load_done,
  output logic                      load_error
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [32:0] MEM_WORDS = 33'd1 << MEM_ADDR_WIDTH;

  state_e state_q, state_d;

  logic [31:0]               len_q, len_d;
  logic [7:0]                csum_q, csum_d;
  logic [TW-1:0]             idle_q, idle_d;
  logic [MEM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]               din_q, din_d;
  logic                      we_q, we_d;
  logic                      hold_q, hold_d;
  logic                      done_q, done_d;
  logic                      err_q, err_d;

  logic        acc, asm_en, asm_clr, wv;
  logic [31:0] word;
  logic        start, timeout, range_bad;
  logic [32:0] span;

  assign rx_ready = 1'b1;
  assign acc      = rx_valid & rx_ready;
  assign asm_clr  = (state_q == ST_IDLE);
  assign asm_en   = acc & ((state_q == ST_LEN)
                         | (state_q == ST_BASE)
                         | (state_q == ST_DATA));

  loader_word_assembler u_asm (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (asm_clr),
    .byte_valid_i (asm_en),
    .byte_i       (rx_data),
    .word_valid_o (wv),
    .word_o       (word)
  );

  // Span computed in 33 bits so a huge LEN cannot wrap past the check.
  assign span      = {3'b000, word[31:2]} + {1'b0, len_q};
  assign range_bad = (|word[1:0]) | (span > MEM_WORDS);
  assign start     = (state_q == ST_IDLE) & acc & (rx_data == SYNC_BYTE);
  assign timeout   = (state_q != ST_IDLE) & ~acc
                   & (idle_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_LEN;
      ST_LEN:  if (wv) state_d = ST_BASE;
      ST_BASE:
        if (wv) begin
          if (range_bad)       state_d = ST_IDLE;
          else if (len_q == 0) state_d = ST_CSUM;
          else                 state_d = ST_DATA;
        end
      ST_DATA: if (wv && len_q == 32'd1) state_d = ST_CSUM;
      ST_CSUM: if (acc) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (timeout) state_d = ST_IDLE;
  end

  always_comb begin
    len_d  = len_q;
    csum_d = csum_q;
    addr_d = addr_q;
    din_d  = din_q;
    we_d   = 1'b0;
    hold_d = hold_q;
    done_d = done_q;
    err_d  = err_q;
    idle_d = (state_q == ST_IDLE || acc) ? '0 : idle_q + 1'b1;
    if (we_q) addr_d = addr_q + 1'b1;
    if (start) begin
      csum_d = '0;
      hold_d = 1'b1;
      done_d = 1'b0;
      err_d  = 1'b0;
    end
    if (state_q == ST_LEN && wv) len_d = word;
    if (state_q == ST_BASE && wv) begin
      if (range_bad) begin
        err_d  = 1'b1;
        hold_d = 1'b0;
      end else begin
        addr_d = word[MEM_ADDR_WIDTH+1:2];
      end
    end
    if (state_q == ST_DATA && acc) begin
      csum_d = csum_q + rx_data;
      if (wv) begin
        we_d  = 1'b1;
        din_d = word;
        len_d = len_q - 32'd1;
      end
    end
    if (state_q == ST_CSUM && acc) begin
      done_d = (rx_data == csum_q);
      err_d  = (rx_data != csum_q);
      hold_d = 1'b0;
    end
    if (timeout) begin
      err_d  = 1'b1;
      hold_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_q  <= '0;
      csum_q <= '0;
      idle_q <= '0;
      addr_q <= '0;
      din_q  <= '0;
      we_q   <= 1'b0;
      hold_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      len_q  <= len_d;
      csum_q <= csum_d;
      idle_q <= idle_d;
      addr_q <= addr_d;
      din_q  <= din_d;
      we_q   <= we_d;
      hold_q <= hold_d;
      done_q <= done_d;
      err_q  <= err_d;
    end
  end

  assign mem_we       = we_q;
  assign mem_wbe      = {4{we_q}};
  assign mem_addr     = addr_q;
  assign mem_din      = din_q;
  assign cpu_rst_hold = hold_q;
  assign load_done    = done_q;
  assign load_error   = err_q;

endmodule

// File: tb/tb_bios_stream_loader.sv
// Self-checking bench for bios_stream_loader: frame table plus
// timeout and mid-frame reset sequences, write scoreboard.
module tb_bios_stream_loader;

  localparam int AW = 12;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [7:0]    rx_data = '0;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  logic          mem_we;
  logic [3:0]    mem_wbe;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_din;
  logic          cpu_rst_hold;
  logic          load_done;
  logic          load_error;

  bios_stream_loader #(
    .MEM_ADDR_WIDTH (AW),
    .SYNC_BYTE      (8'hA5),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .mem_we       (mem_we),
    .mem_wbe      (mem_wbe),
    .mem_addr     (mem_addr),
    .mem_din      (mem_din),
    .cpu_rst_hold (cpu_rst_hold),
    .load_done    (load_done),
    .load_error   (load_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned n;
    logic [31:0] base;
    logic [31:0] w0;
    logic [31:0] w1;
    bit          lead;
    bit          csum_ok;
    bit          hdr_only;
    bit          exp_done;
    bit          exp_err;
    int unsigned exp_wr;
    int unsigned gap;
  } vec_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  int   nchecks = 0;
  int   nerr = 0;
  wr_t  exp_q[$];
  vec_t vecs[8];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst && mem_we) begin
      wr_t e;
      if (exp_q.size() == 0) begin
        nchecks++;
        nerr++;
        $display("FAIL unexpected_write: addr %h din %h", mem_addr, mem_din);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(mem_addr), 32'(e.addr));
        chk("wr_din", mem_din, e.data);
        chk("wr_wbe", 32'(mem_wbe), 32'hF);
      end
    end
  end

  task automatic send_byte(logic [7:0] b, int unsigned gap);
    if (gap != 0) begin
      @(negedge clk);
      rx_valid = 1'b0;
      repeat ($urandom_range(gap)) @(negedge clk);
    end
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
  endtask

  task automatic send_word(logic [31:0] w, int unsigned gap);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap);
  endtask

  task automatic idle_bus();
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  function automatic logic [7:0] sum_word(logic [31:0] w);
    return w[7:0] + w[15:8] + w[23:16] + w[31:24];
  endfunction

  task automatic send_frame(vec_t v);
    logic [31:0] ws[2];
    logic [7:0]  cs;
    wr_t         e;
    ws[0] = v.w0;
    ws[1] = v.w1;
    cs = '0;
    if (v.lead) begin
      send_byte(8'h00, v.gap);
      send_byte(8'hFF, v.gap);
    end
    send_byte(8'hA5, v.gap);
    #1;
    chk("hold_after_sync", 32'(cpu_rst_hold), 32'd1);
    chk("flags_cleared", {30'd0, load_done, load_error}, 32'd0);
    send_word(v.n, v.gap);
    send_word(v.base, v.gap);
    if (!v.hdr_only) begin
      for (int i = 0; i < int'(v.n); i++) begin
        if (i < int'(v.exp_wr)) begin
          e.addr = AW'(v.base[31:2] + 32'(i));
          e.data = ws[i];
          exp_q.push_back(e);
        end
        cs = cs + sum_word(ws[i]);
        send_word(ws[i], v.gap);
      end
      send_byte(v.csum_ok ? cs : cs + 8'h5A, v.gap);
    end
    @(negedge clk);
    rx_valid = 1'b0;
    chk("load_done", 32'(load_done), 32'(v.exp_done));
    chk("load_error", 32'(load_error), 32'(v.exp_err));
    chk("hold_end", 32'(cpu_rst_hold), 32'd0);
    repeat (2) @(negedge clk);
    chk("writes_left", exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{2, 32'h10, 32'h12C, 32'h1F4, 0, 1, 0, 1, 0, 2, 0};
    vecs[1] = '{1, 32'h0, 32'hDEADBEEF, 32'h0, 1, 1, 0, 1, 0, 1, 0};
    vecs[2] = '{1, 32'h0, 32'hDEADBEEF, 32'h0, 0, 0, 0, 0, 1, 1, 0};
    vecs[3] = '{2, 32'h3FFC, 32'h1, 32'h2, 0, 1, 1, 0, 1, 0, 0};
    vecs[4] = '{2, 32'h2, 32'h1, 32'h2, 0, 1, 1, 0, 1, 0, 0};
    vecs[5] = '{0, 32'h40, 32'h0, 32'h0, 0, 1, 0, 1, 0, 0, 0};
    vecs[6] = '{1, 32'h3FFC, 32'h89ABCDEF, 32'h0, 0, 1, 0, 1, 0, 1, 0};
    vecs[7] = '{2, 32'h20, 32'hA5A5A5A5, 32'h13570A5, 1, 1, 0, 1, 0, 2, 3};

    #12;
    chk("rst_ready", 32'(rx_ready), 32'd1);
    chk("rst_outs", {26'd0, mem_we, mem_wbe, cpu_rst_hold}, 32'd0);
    chk("rst_flags", {30'd0, load_done, load_error}, 32'd0);
    chk("rst_addr_din", 32'(mem_addr) | mem_din, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++) send_frame(vecs[i]);

    // Stall after 2nd data byte until the idle counter expires.
    send_byte(8'hA5, 0);
    send_word(32'd1, 0);
    send_word(32'd0, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    idle_bus();
    repeat (TO - 1) @(posedge clk);
    @(negedge clk);
    chk("to_not_yet_err", 32'(load_error), 32'd0);
    chk("to_not_yet_hold", 32'(cpu_rst_hold), 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("to_err", 32'(load_error), 32'd1);
    chk("to_hold", 32'(cpu_rst_hold), 32'd0);
    repeat (3) @(negedge clk);
    chk("to_no_write", exp_q.size(), 32'd0);

    // Reset in the middle of the second data word.
    begin
      wr_t e;
      send_byte(8'hA5, 0);
      send_word(32'd2, 0);
      send_word(32'h8, 0);
      e.addr = AW'(2);
      e.data = 32'hCAFEF00D;
      exp_q.push_back(e);
      send_word(32'hCAFEF00D, 0);
      send_byte(8'h01, 0);
      send_byte(8'h02, 0);
      idle_bus();
      @(negedge clk);
      chk("mid_write_done", exp_q.size(), 32'd0);
      #2 rst = 1'b0;
      #1;
      chk("mr_hold", 32'(cpu_rst_hold), 32'd0);
      chk("mr_outs", {26'd0, mem_we, mem_wbe, load_done}, 32'd0);
      chk("mr_addr_din", 32'(mem_addr) | mem_din, 32'd0);
      chk("mr_err", 32'(load_error), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
    end
    send_frame(vecs[1]);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
